// File: rtl/tx_vc_sched.sv
// -----------------------------------------------------------------------------
// router_pkg / tx_vc_sched
//
// router_pkg holds the flit types shared with the router: the flit type
// encoding, the head (type + VC id) and the channel_t flit carried on the link.
//
// tx_vc_sched is the injection-side VC scheduler. Each cycle it picks at most
// one eligible virtual channel in round-robin order, forwards that VC's flit to
// the router local port one cycle later (stamped with the VC id), and tracks
// per-VC downstream credits and per-VC packet framing.
//
// Ports
//   clk              in   clock, all state on the rising edge
//   rst              in   synchronous active-high reset
//   en               in   scheduling enable (low: no new grants)
//   vc_req_valid     in   [NUM_VCS] flit pending per VC
//   vc_req_flit      in   [NUM_VCS] channel_t pending flit per VC
//   vc_req_ready     out  [NUM_VCS] combinational one-hot grant
//   flit_to_noc      out  channel_t registered flit to the router
//   credits_from_noc in   [NUM_VCS] one-cycle credit return pulses
//   credit_cnt       out  [NUM_VCS] current credits per VC
//   proto_err        out  sticky framing / credit violation flag
// -----------------------------------------------------------------------------
package router_pkg;
  localparam int NUM_VCS     = 2;
  localparam int VCID_W      = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int FLIT_DATA_W = 16;

  // I must stay at encoding zero: an all-zero flit is the idle flit.
  typedef enum logic [2:0] {
    I  = 3'd0,
    H  = 3'd1,
    B  = 3'd2,
    T  = 3'd3,
    HT = 3'd4
  } ftype_t;

  typedef struct packed {
    ftype_t              ftype;
    logic [VCID_W-1:0]   fvcid;
  } head_t;

  typedef struct packed {
    head_t                  head;
    logic [FLIT_DATA_W-1:0] payload;
  } channel_t;
endpackage

module tx_vc_sched #(
  parameter int NUM_VCS       = router_pkg::NUM_VCS,
  parameter int BUF_DEPTH     = 4,
  // Lets an environment that deliberately provokes violations observe
  // proto_err without the simulator report.
  parameter bit REPORT_ERRORS = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [NUM_VCS-1:0]               vc_req_valid,
  input  router_pkg::channel_t             vc_req_flit [NUM_VCS],
  output logic [NUM_VCS-1:0]               vc_req_ready,
  output router_pkg::channel_t             flit_to_noc,
  input  logic [NUM_VCS-1:0]               credits_from_noc,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   credit_cnt [NUM_VCS],
  output logic                             proto_err
);

  localparam int CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int SUM_W   = PTR_W + 1;
  localparam int FVCID_W = router_pkg::VCID_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_DEPTH);

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_IN_PKT = 1'b1
  } vc_state_t;

  vc_state_t            vc_state     [NUM_VCS];
  vc_state_t            vc_state_nxt [NUM_VCS];

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_ptr_nxt;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic [SUM_W-1:0]     arb_sum;
  logic [NUM_VCS-1:0]   eligible;
  logic [NUM_VCS-1:0]   gnt_onehot;
  logic [NUM_VCS-1:0]   cnt_full;
  logic [NUM_VCS-1:0]   cred_ovf;
  logic                 seq_err;
  logic                 cred_err;
  router_pkg::channel_t gnt_flit;
  router_pkg::channel_t flit_p1;

  // ---- stage 0: eligibility and round-robin grant (combinational) ----
  always_comb begin
    eligible = '0;
    cnt_full = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      // Reset masks every request so a mid-packet reset cannot leak a grant.
      eligible[v] = !rst && en && vc_req_valid[v] && (credit_cnt[v] != '0) &&
                    (vc_req_flit[v].head.ftype != router_pkg::I);
      cnt_full[v] = (credit_cnt[v] == CNT_MAX);
    end
  end

  // Scanning from the lowest priority up lets the last hit (offset 0 from
  // rr_ptr) win without an early exit.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    arb_sum = '0;
    for (int i = NUM_VCS - 1; i >= 0; i--) begin
      arb_sum = {1'b0, rr_ptr} + SUM_W'(i);
      if (arb_sum >= SUM_W'(NUM_VCS)) begin
        arb_sum = arb_sum - SUM_W'(NUM_VCS);
      end
      if (eligible[arb_sum[PTR_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = arb_sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_onehot = gnt_vld ? (NUM_VCS'(1) << gnt_idx) : '0;
    rr_ptr_nxt = rr_ptr;
    if (gnt_vld) begin
      rr_ptr_nxt = (gnt_idx == PTR_W'(NUM_VCS - 1)) ? '0 : gnt_idx + 1'b1;
    end
    // A return on a full counter is only an overflow if the same VC is not
    // also spending a credit this cycle.
    cred_ovf = credits_from_noc & ~gnt_onehot & cnt_full;
    cred_err = |cred_ovf;
  end

  assign vc_req_ready = gnt_onehot;

  always_comb begin
    gnt_flit = '0;
    if (gnt_vld) begin
      gnt_flit            = vc_req_flit[gnt_idx];
      gnt_flit.head.fvcid = FVCID_W'(gnt_idx);
    end
  end

  // Packet framing: an illegal type is still forwarded but leaves the state.
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      vc_state_nxt[v] = vc_state[v];
    end
    seq_err = 1'b0;
    if (gnt_vld) begin
      if (vc_state[gnt_idx] == VC_IDLE) begin
        if (gnt_flit.head.ftype == router_pkg::H) begin
          vc_state_nxt[gnt_idx] = VC_IN_PKT;
        end else if (gnt_flit.head.ftype != router_pkg::HT) begin
          seq_err = 1'b1;
        end
      end else begin
        if (gnt_flit.head.ftype == router_pkg::T) begin
          vc_state_nxt[gnt_idx] = VC_IDLE;
        end else if (gnt_flit.head.ftype != router_pkg::B) begin
          seq_err = 1'b1;
        end
      end
    end
  end

  // ---- stage 1: registered flit, credits, framing state, error flag ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      proto_err <= 1'b0;
      flit_p1   <= '0;
      for (int v = 0; v < NUM_VCS; v++) begin
        credit_cnt[v] <= CNT_MAX;
      end
    end else begin
      rr_ptr    <= rr_ptr_nxt;
      proto_err <= proto_err | seq_err | cred_err;
      flit_p1   <= gnt_flit;
      for (int v = 0; v < NUM_VCS; v++) begin
        if (credits_from_noc[v] && !gnt_onehot[v] && !cnt_full[v]) begin
          credit_cnt[v] <= credit_cnt[v] + 1'b1;
        end else if (gnt_onehot[v] && !credits_from_noc[v]) begin
          credit_cnt[v] <= credit_cnt[v] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (rst) begin
        vc_state[v] <= VC_IDLE;
      end else begin
        vc_state[v] <= vc_state_nxt[v];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (REPORT_ERRORS && !rst) begin
      if (seq_err) begin
        $error("tx_vc_sched: illegal ftype %0d on VC %0d", gnt_flit.head.ftype, gnt_idx);
      end
      if (cred_err) begin
        $error("tx_vc_sched: credit return overflow, VC mask %b", cred_ovf);
      end
    end
  end

  assign flit_to_noc = flit_p1;

endmodule

// File: doc/tx_vc_sched.md
TX_VC_SCHED -- requirements
Module: tx_vc_sched

Interface
REQ-001 SHALL take parameter NUM_VCS, default router_pkg NUM_VCS: number of virtual channels on the injection link.
REQ-002 SHALL take parameter BUF_DEPTH, default 4: downstream flit buffer depth per VC, which is the initial credit count.
REQ-003 SHALL expose clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL expose rst  input  1  reset; one clock, synchronous and active-high.
REQ-005 SHALL expose en  input  1  scheduling enable; when low, no grants are issued.
REQ-006 SHALL expose vc_req_valid[NUM_VCS]  input  1 each  a flit is pending on that VC.
REQ-007 SHALL expose vc_req_flit[NUM_VCS]  input  channel_t each  pending flit for that VC.
REQ-008 SHALL expose vc_req_ready[NUM_VCS]  output  1 each  grant/accept; the flit is consumed when valid and ready are both high in the same cycle.
REQ-009 SHALL expose flit_to_noc  output  channel_t  registered flit to the router local port.
REQ-010 SHALL expose credits_from_noc[NUM_VCS]  input  1 each  one-cycle credit return pulse per VC.
REQ-011 SHALL expose credit_cnt[NUM_VCS]  output  $clog2(BUF_DEPTH+1) each  current credits per VC.
REQ-012 SHALL expose proto_err  output  1  sticky flit-sequence violation flag.

Function
REQ-013 SHALL treat VC v as eligible when en=1, vc_req_valid[v]=1 and credit_cnt[v]>0.
REQ-014 SHALL grant at most one eligible VC per cycle, round-robin starting from pointer rr_ptr.
REQ-015 SHALL drive vc_req_ready combinationally, one-hot or zero, high only on the granted VC.
REQ-016 SHALL, after a grant to VC g, set rr_ptr to (g+1) mod NUM_VCS; with no grant, rr_ptr is unchanged.
REQ-017 SHALL register the granted flit to flit_to_noc on the next edge (1-cycle latency), with head.fvcid overwritten to g and all other fields unchanged.
REQ-018 SHALL, in a cycle with no grant, register flit_to_noc = all zero with head.ftype = I.
REQ-019 SHALL update each credit counter per cycle:
- grant only: decrement by 1
- credit return only: increment by 1
- both in the same cycle: unchanged
REQ-020 SHALL, on a credit return with credit_cnt[v]==BUF_DEPTH and no grant on v, hold the count at BUF_DEPTH, set proto_err and raise $error.
REQ-021 SHALL keep a per-VC state, IDLE or IN_PKT, updated only on accepted flits:
- IDLE + H -> IN_PKT
- IDLE + HT -> IDLE
- IN_PKT + B -> IN_PKT
- IN_PKT + T -> IDLE
REQ-022 SHALL, on any other accepted ftype/state combination (B or T in IDLE; H or HT in IN_PKT; I accepted), set proto_err, raise $error, still forward the flit, and leave the state unchanged.
REQ-023 SHALL ignore a valid with ftype I: the VC is not eligible and is never granted.
REQ-024 SHALL hold proto_err high until reset once set.
REQ-025 SHALL let en=0 block only new grants; credit returns are still counted and flit_to_noc goes to I on the next edge.

Reset
REQ-026 SHALL, when rst=1 at an edge:
- set credit_cnt[all] = BUF_DEPTH
- set rr_ptr = 0
- set all VC states to IDLE
- clear proto_err
- set flit_to_noc = zero with ftype I
REQ-027 SHALL drive vc_req_ready all zero while rst=1, including when reset is asserted mid-packet; any in-flight packet is abandoned and no error is flagged.

Verification
REQ-028 SHALL cover: BUF_DEPTH=4, VC0 holds valid HT flits continuously, no credit returns -> exactly 4 grants, then credit_cnt[0]=0 and ready[0] stays low; one credit pulse -> exactly one more grant.
REQ-029 SHALL cover: NUM_VCS=2, both VCs valid with full credits from reset -> grant order VC0, VC1, VC0, VC1; flit_to_noc.head.fvcid follows one cycle later.
REQ-030 SHALL cover: VC1 sends H,B,B,T with payloads 0..3 -> flit_to_noc shows the same sequence and fvcid=1, proto_err stays 0, and the VC1 state returns to IDLE.
REQ-031 SHALL cover: VC0 sends B while IDLE -> proto_err=1 from the next edge, the flit is still forwarded, and proto_err persists until rst.
REQ-032 SHALL cover: grant and credit return on VC0 in the same cycle with credit_cnt=2 -> count remains 2; credit return at count 4 with no grant -> count stays 4 and proto_err=1.
REQ-033 SHALL cover: rst asserted after the H flit of a packet -> the next cycle shows all credits =4, flit_to_noc ftype I, no ready, and a new H on that VC is accepted with no error.
